// File: rtl/mem_responder.sv
// Word-addressed memory responder with fixed response latency.
//
// A request is accepted in IDLE, held for LATENCY wait cycles, then
// answered with a one-cycle ready strobe. The array access (write or read)
// happens on the edge that enters RESP. Misaligned or out-of-range
// requests answer with err=1 and rdata=0, and leave the array unchanged.
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous, active-high reset
//   req    in   request valid (sampled only in IDLE)
//   we     in   1 = write, 0 = read
//   addr   in   byte address, word index = addr[31:2]
//   wdata  in   write data
//   rdata  out  registered read data, valid while ready=1
//   ready  out  one-cycle response strobe
//   err    out  error flag, valid while ready=1
//   busy   out  high whenever the FSM is not IDLE
module mem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  // Access operands: with zero latency the access happens on the accepting
  // edge itself, so the live inputs are used while still in IDLE.
  logic          acc_we;
  logic [31:0]   acc_addr, acc_wdata;
  logic          acc_bad;
  logic [AW-1:0] acc_idx;
  logic          enter_resp;
  logic          mem_wr;

  always_comb begin
    if (state_q == StIdle) begin
      acc_we    = we;
      acc_addr  = addr;
      acc_wdata = wdata;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
    acc_bad = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= DEPTH);
    acc_idx = acc_addr[2 +: AW];
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          cnt_d = 4'(LATENCY);
          if (LATENCY == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        // Counter is only decremented while nonzero, so it never wraps.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end
        if (cnt_q <= 4'd1) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Response data is produced on the edge entering RESP.
  always_comb begin
    enter_resp = (state_d == StResp) && (state_q != StResp);
    mem_wr     = enter_resp && acc_we && !acc_bad && !reset;
    rdata_d    = rdata_q;
    err_d      = err_q;
    if (enter_resp) begin
      err_d = acc_bad;
      if (acc_bad) begin
        rdata_d = 32'h0;
      end else if (!acc_we) begin
        rdata_d = mem[acc_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == StIdle && req) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end

  // Array has no reset; its contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign rdata = rdata_q;
  assign err   = err_q;
  assign ready = (state_q == StResp);
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: four instances with LATENCY 2, 0, 3, 4
// share data inputs but each has its own req. A vector table covers the
// single-request behaviour; hand sequences cover zero-latency busy, back-to-back
// throughput and reset during a pending request.
module tb_mem_responder;

  localparam int unsigned LAT0 = 2;
  localparam int unsigned LAT1 = 0;
  localparam int unsigned LAT2 = 3;
  localparam int unsigned LAT3 = 4;

  logic        clk;
  logic        reset;
  logic        we;
  logic [31:0] addr, wdata;
  logic        req_v   [4];
  logic [31:0] rdata_v [4];
  logic        ready_v [4];
  logic        err_v   [4];
  logic        busy_v  [4];

  int checks;
  int errors;
  int lat_of [4];

  mem_responder #(.DEPTH(64), .LATENCY(LAT0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req_v[0]), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_v[0]), .ready(ready_v[0]), .err(err_v[0]), .busy(busy_v[0])
  );
  mem_responder #(.DEPTH(64), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req_v[1]), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_v[1]), .ready(ready_v[1]), .err(err_v[1]), .busy(busy_v[1])
  );
  mem_responder #(.DEPTH(64), .LATENCY(LAT2)) u_dut2 (
    .clk(clk), .reset(reset), .req(req_v[2]), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_v[2]), .ready(ready_v[2]), .err(err_v[2]), .busy(busy_v[2])
  );
  mem_responder #(.DEPTH(64), .LATENCY(LAT3)) u_dut3 (
    .clk(clk), .reset(reset), .req(req_v[3]), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_v[3]), .ready(ready_v[3]), .err(err_v[3]), .busy(busy_v[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // One request on instance i. After acceptance the inputs are scrambled
  // (we inverted, addr -> a2, wdata inverted) to show they are ignored.
  // lat counts falling edges from acceptance until ready is seen.
  task automatic do_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] a2, output logic [31:0] rd, output logic e,
                        output int lat);
    @(negedge clk);
    req_v[i] = 1'b1;
    we       = w;
    addr     = a;
    wdata    = d;
    @(negedge clk);
    req_v[i] = 1'b0;
    we       = ~w;
    addr     = a2;
    wdata    = ~d;
    lat      = 1;
    while (ready_v[i] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = rdata_v[i];
    e  = err_v[i];
  endtask

  typedef struct {
    int          inst;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] a2;
    logic [31:0] rd;
    logic        e;
  } vec_t;

  vec_t tab [17];

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          last;
    int          n_pulse;
    int          rdy_seen;
    logic [31:0] exp_rd;

    checks   = 0;
    errors   = 0;
    lat_of   = '{LAT0, LAT1, LAT2, LAT3};
    reset    = 1'b1;
    we       = 1'b0;
    addr     = 32'h0;
    wdata    = 32'h0;
    for (int i = 0; i < 4; i++) req_v[i] = 1'b0;

    //          inst w     addr        wdata         addr-after   exp rdata     exp err
    tab[0]  = '{0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h14,  32'h00000000, 1'b0};
    tab[1]  = '{0, 1'b0, 32'h10,  32'h00000000, 32'h100, 32'hDEADBEEF, 1'b0};
    tab[2]  = '{0, 1'b1, 32'h13,  32'h11111111, 32'h10,  32'h00000000, 1'b1};
    tab[3]  = '{0, 1'b1, 32'h100, 32'h22222222, 32'h10,  32'h00000000, 1'b1};
    tab[4]  = '{0, 1'b0, 32'h10,  32'h00000000, 32'h13,  32'hDEADBEEF, 1'b0};
    tab[5]  = '{0, 1'b0, 32'h100, 32'h00000000, 32'h10,  32'h00000000, 1'b1};
    tab[6]  = '{0, 1'b1, 32'hFC,  32'h600DF00D, 32'h10,  32'h00000000, 1'b0};
    tab[7]  = '{0, 1'b0, 32'hFC,  32'h00000000, 32'h100, 32'h600DF00D, 1'b0};
    tab[8]  = '{0, 1'b1, 32'h20,  32'h77777777, 32'hFC,  32'h600DF00D, 1'b0};
    tab[9]  = '{0, 1'b0, 32'h11,  32'h00000000, 32'h10,  32'h00000000, 1'b1};
    tab[10] = '{1, 1'b1, 32'h0,   32'h55AA55AA, 32'h4,   32'h00000000, 1'b0};
    tab[11] = '{1, 1'b0, 32'h0,   32'h00000000, 32'h4,   32'h55AA55AA, 1'b0};
    tab[12] = '{2, 1'b1, 32'h20,  32'h0BADC0DE, 32'h8,   32'h00000000, 1'b0};
    tab[13] = '{2, 1'b1, 32'h8,   32'h12345678, 32'h20,  32'h00000000, 1'b0};
    tab[14] = '{2, 1'b0, 32'h8,   32'h00000000, 32'h20,  32'h12345678, 1'b0};
    tab[15] = '{2, 1'b0, 32'h20,  32'h00000000, 32'h8,   32'h0BADC0DE, 1'b0};
    tab[16] = '{3, 1'b1, 32'h4,   32'h01020304, 32'h8,   32'h00000000, 1'b0};

    // Reset state
    #12;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst%0d_rdata", i), rdata_v[i], 32'h0);
      check($sformatf("rst%0d_flags", i), {29'b0, ready_v[i], err_v[i], busy_v[i]}, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Table-driven single requests
    for (int k = 0; k < 17; k++) begin
      do_req(tab[k].inst, tab[k].w, tab[k].a, tab[k].d, tab[k].a2, rd, e, lat);
      check($sformatf("v%0d_rdata", k), rd, tab[k].rd);
      check($sformatf("v%0d_err", k), 32'(e), 32'(tab[k].e));
      check($sformatf("v%0d_latency", k), 32'(lat), 32'(lat_of[tab[k].inst] + 1));
    end

    // Zero latency: ready and busy for exactly the cycle after acceptance
    @(negedge clk);
    req_v[1] = 1'b1;
    we       = 1'b0;
    addr     = 32'h0;
    @(negedge clk);
    req_v[1] = 1'b0;
    check("l0_ready", 32'(ready_v[1]), 32'd1);
    check("l0_busy", 32'(busy_v[1]), 32'd1);
    check("l0_rdata", rdata_v[1], 32'h55AA55AA);
    @(negedge clk);
    check("l0_busy_after", 32'(busy_v[1]), 32'd0);
    check("l0_ready_after", 32'(ready_v[1]), 32'd0);

    // Back-to-back reads with req held high, alternating words
    @(negedge clk);
    req_v[0] = 1'b1;
    we       = 1'b0;
    addr     = 32'h10;
    exp_rd   = 32'hDEADBEEF;
    last     = 0;
    n_pulse  = 0;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      if (ready_v[0] === 1'b1) begin
        n_pulse++;
        if (n_pulse == 1) check("b2b_first", 32'(c), 32'd3);
        else check($sformatf("b2b_gap%0d", n_pulse), 32'(c - last), 32'd4);
        check($sformatf("b2b_rdata%0d", n_pulse), rdata_v[0], exp_rd);
        last   = c;
        addr   = (addr == 32'h10) ? 32'hFC : 32'h10;
        exp_rd = (exp_rd == 32'hDEADBEEF) ? 32'h600DF00D : 32'hDEADBEEF;
      end
    end
    req_v[0] = 1'b0;
    check("b2b_pulses", 32'(n_pulse), 32'd6);
    repeat (4) @(negedge clk);

    // Reset during WAIT aborts the write
    req_v[3] = 1'b1;
    we       = 1'b1;
    addr     = 32'h4;
    wdata    = 32'hCAFEF00D;
    @(negedge clk);
    req_v[3] = 1'b0;
    check("abort_busy_wait", 32'(busy_v[3]), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_async_busy", 32'(busy_v[3]), 32'd0);
    check("abort_async_ready", 32'(ready_v[3]), 32'd0);
    rdy_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (ready_v[3] === 1'b1) rdy_seen++;
    end
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ready_v[3] === 1'b1) rdy_seen++;
    end
    check("abort_no_ready", 32'(rdy_seen), 32'd0);
    do_req(3, 1'b0, 32'h4, 32'h0, 32'h8, rd, e, lat);
    check("abort_read_rdata", rd, 32'h01020304);
    check("abort_read_err", 32'(e), 32'd0);
    check("abort_read_latency", 32'(lat), 32'(LAT3 + 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, 64: number of 32-bit words in the memory array.
REQ-002 Parameter LATENCY, 2: wait cycles inserted before each response (0..15).
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 req  input  1  request valid from the multicycle controller/datapath.
REQ-006 we  input  1  1 = write request, 0 = read request; sampled with req.
REQ-007 addr  input  32  byte address; word index = addr[31:2].
REQ-008 wdata  input  32  write data; sampled with req.
REQ-009 rdata  output  32  registered read data; valid while ready=1.
REQ-010 ready  output  1  one-cycle response strobe; completes the current request.
REQ-011 err  output  1  error flag; valid only while ready=1.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states SHALL be IDLE, WAIT and RESP.
REQ-014 In IDLE with req=1, the block SHALL capture we, addr and wdata and load the wait counter with LATENCY.
- Next state: WAIT if LATENCY>0, else RESP.
REQ-015 In IDLE with req=0, the block SHALL remain in IDLE with all outputs unchanged except ready=0.
REQ-016 In WAIT, the counter SHALL decrement once per cycle, and the FSM SHALL go to RESP on the cycle the counter reaches 0.
REQ-017 req, we, addr and wdata SHALL be ignored in WAIT and RESP, so input changes after acceptance do not affect the captured request.
REQ-018 The array access SHALL happen on the edge entering RESP:
- Write: the captured wdata is stored at the captured word index.
- Read: rdata is loaded from the captured word index.
REQ-019 ready SHALL be 1 for exactly one cycle, while in RESP; the FSM then returns to IDLE unconditionally.
REQ-020 Latency SHALL be fixed: ready is high LATENCY+1 cycles after the accepting edge.
REQ-021 The requester SHALL drop req in the cycle ready=1; if req is still 1 in the following IDLE cycle, that is a new request.
- Maximum throughput is one request per LATENCY+2 cycles.
REQ-022 A misaligned request (captured addr[1:0]!=00) SHALL respond with err=1, rdata=0 and no array write.
REQ-023 An out-of-range request (captured addr[31:2] >= DEPTH) SHALL respond with err=1, rdata=0 and no array write.
REQ-024 A valid request SHALL respond with err=0.
REQ-025 On writes, rdata SHALL keep its previous value.
REQ-026 A read following a write to the same word SHALL return the written data.
- No forwarding is needed because accesses never overlap.
REQ-027 The wait counter SHALL be 4 bits wide and SHALL never wrap.
- It is loaded only in IDLE and decremented only while nonzero.

Reset
REQ-028 On reset, the block SHALL set state=IDLE, ready=0, err=0, rdata=0, busy=0 and wait counter=0, independent of clk.
REQ-029 Memory array contents SHALL NOT be cleared by reset.
REQ-030 A reset asserted during WAIT or RESP SHALL abort the request: no write occurs and no ready is issued.
REQ-031 After reset deasserts, the first rising edge with req=1 SHALL be accepted as a new request.

Verification
REQ-032 Basic write then read, LATENCY=2:
- Stimulus: write addr=0x10, wdata=0xDEADBEEF, then read addr=0x10.
- Response: each ready occurs 3 cycles after acceptance; read returns rdata=0xDEADBEEF with err=0.
REQ-033 Zero latency, LATENCY=0:
- Stimulus: read addr=0x0.
- Response: ready=1 on the cycle after acceptance; busy is high for 1 cycle.
REQ-034 Error cases:
- Stimulus: write addr=0x13 (misaligned), then write addr=0x100 with DEPTH=64 (out of range).
- Response: both give err=1 and rdata=0; a later read of word 4 returns its old value.
- Stimulus: a read of addr=0x100.
- Response: rdata=0, err=1.
REQ-035 Input change after acceptance, LATENCY=3:
- Stimulus: read addr=0x8 holding 0x12345678; one cycle after acceptance, change addr to 0x20.
- Response: rdata=0x12345678.
REQ-036 Reset mid-operation, LATENCY=4:
- Stimulus: write 0xCAFEF00D to addr=0x4; pulse reset during WAIT; then read addr=0x4.
- Response: ready never asserts for the aborted write; the read returns the pre-write value.
REQ-037 Back-to-back requests:
- Stimulus: hold req=1 continuously with alternating addresses.
- Response: ready pulses exactly every LATENCY+2 cycles; no ready is ever asserted for 2 consecutive cycles.
